// File: rtl/axi_wr_slave_sram.sv
// AXI4 write-channel responder that turns each W beat into a one-cycle SRAM write.
// Optional one-entry AW holding register enabled by AXI_WR_SLAVE_AW_PREFETCH_EN.
module axi_wr_slave_sram #(
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ID_WIDTH-1:0]       axi_awid,
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
  input  logic [7:0]                axi_awlen,
  input  logic [2:0]                axi_awsize,
  input  logic [1:0]                axi_awburst,
  input  logic                      axi_awlock,
  input  logic [3:0]                axi_awcache,
  input  logic [2:0]                axi_awprot,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [DATA_WIDTH-1:0]     axi_wdata,
  input  logic [STRB_WIDTH-1:0]     axi_wstrb,
  input  logic                      axi_wlast,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [ID_WIDTH-1:0]       axi_bid,
  output logic                      axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [STRB_WIDTH-1:0]     mem_wstrb
);

  localparam int unsigned Offs  = $clog2(STRB_WIDTH);
  localparam int unsigned HiBit = Offs + MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic                      err_q, err_d;
  logic [8:0]                cnt_q, cnt_d;

  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic                      bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]       bid_q, bid_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0]     mem_wstrb_q, mem_wstrb_d;

  logic aw_hs, w_hs, b_hs;
  logic load, load_hold, last_cnt;

  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_burst;

  logic [ADDR_WIDTH-1:0] step, wrap_mask, addr_inc, addr_nxt;

  logic unused_aw_attr;
  assign unused_aw_attr = ^{axi_awlock, axi_awcache, axi_awprot};

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_bid     = bid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;

  assign aw_hs = axi_awvalid && awready_q;
  assign w_hs  = axi_wvalid && wready_q;
  assign b_hs  = bvalid_q && axi_bready;

  function automatic logic cmd_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic bad;
    bad = ({29'd0, size} > Offs) || (burst == 2'b11);
    if ((addr >> HiBit) != '0) bad = 1'b1;
    if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1'b1;
    return bad;
  endfunction

  // Next beat address; window math only meaningful for legal WRAP lengths.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    addr_inc  = addr_q + step;
    unique case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_nxt = addr_inc;
    endcase
  end

`ifdef AXI_WR_SLAVE_AW_PREFETCH_EN
  logic                  hold_valid_q, hold_valid_d;
  logic [ID_WIDTH-1:0]   hold_id_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [7:0]            hold_len_q;
  logic [2:0]            hold_size_q;
  logic [1:0]            hold_burst_q;
  logic                  aw_to_hold;

  assign cmd_id    = load_hold ? hold_id_q    : axi_awid;
  assign cmd_addr  = load_hold ? hold_addr_q  : axi_awaddr;
  assign cmd_len   = load_hold ? hold_len_q   : axi_awlen;
  assign cmd_size  = load_hold ? hold_size_q  : axi_awsize;
  assign cmd_burst = load_hold ? hold_burst_q : axi_awburst;

  // A command arriving while busy parks here unless it is consumed directly on the B handshake.
  assign aw_to_hold = aw_hs && (state_q != StIdle) && !(load && !load_hold);

  always_comb begin
    hold_valid_d = hold_valid_q;
    if (load_hold) hold_valid_d = 1'b0;
    if (aw_to_hold) hold_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_id_q    <= '0;
      hold_addr_q  <= '0;
      hold_len_q   <= '0;
      hold_size_q  <= '0;
      hold_burst_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      if (aw_to_hold) begin
        hold_id_q    <= axi_awid;
        hold_addr_q  <= axi_awaddr;
        hold_len_q   <= axi_awlen;
        hold_size_q  <= axi_awsize;
        hold_burst_q <= axi_awburst;
      end
    end
  end
`else
  assign cmd_id    = axi_awid;
  assign cmd_addr  = axi_awaddr;
  assign cmd_len   = axi_awlen;
  assign cmd_size  = axi_awsize;
  assign cmd_burst = axi_awburst;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_hold = 1'b0;
    last_cnt  = (cnt_q == {1'b0, len_q});

    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          load    = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          cnt_d  = cnt_q + 9'd1;
          addr_d = addr_nxt;
          if (last_cnt || axi_wlast) begin
            state_d = StResp;
            if (last_cnt != axi_wlast) err_d = 1'b1;
          end
        end
      end
      StResp: begin
        if (b_hs) begin
          state_d = StIdle;
`ifdef AXI_WR_SLAVE_AW_PREFETCH_EN
          if (hold_valid_q) begin
            load      = 1'b1;
            load_hold = 1'b1;
            state_d   = StData;
          end else if (aw_hs) begin
            load    = 1'b1;
            state_d = StData;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      id_d    = cmd_id;
      addr_d  = cmd_addr;
      len_d   = cmd_len;
      size_d  = cmd_size;
      burst_d = cmd_burst;
      err_d   = cmd_err(cmd_addr, cmd_len, cmd_size, cmd_burst);
      cnt_d   = '0;
    end
  end

  always_comb begin
`ifdef AXI_WR_SLAVE_AW_PREFETCH_EN
    awready_d = (state_d == StIdle) || !hold_valid_d;
`else
    awready_d = (state_d == StIdle);
`endif
    wready_d    = (state_d == StData);
    bvalid_d    = (state_d == StResp);
    bresp_d     = (state_d == StResp) && err_d;
    bid_d       = (state_d == StResp) ? id_d : '0;
    mem_we_d    = w_hs && !err_q;
    mem_addr_d  = w_hs ? addr_q[Offs +: MEM_ADDR_WIDTH] : mem_addr_q;
    mem_wdata_d = w_hs ? axi_wdata : mem_wdata_q;
    mem_wstrb_d = w_hs ? axi_wstrb : mem_wstrb_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 1'b0;
      bid_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_sram.sv
// Scoreboard bench for axi_wr_slave_sram: expected SRAM writes and B responses are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_axi_wr_slave_sram;

  logic        clk;
  logic        rst_n;
  logic [7:0]  axi_awid;
  logic [15:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awlock;
  logic [3:0]  axi_awcache;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [7:0]  axi_bid;
  logic        axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  axi_wr_slave_sram dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awlock  (axi_awlock),
    .axi_awcache (axi_awcache),
    .axi_awprot  (axi_awprot),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  typedef struct packed {
    logic [7:0] id;
    logic       resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  int  wr_cyc[$];
  wr_t mon_w;
  b_t  mon_b;
  int  checks;
  int  errors;
  int  cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d strb=%h, required no write", mem_addr,
                 mem_wstrb);
      end else begin
        mon_w = exp_wr.pop_front();
        if ({mem_addr, mem_wdata, mem_wstrb} !== mon_w) begin
          errors++;
          $display("FAIL mem_write got addr=%0d data=%h strb=%h, required addr=%0d data=%h strb=%h",
                   mem_addr, mem_wdata, mem_wstrb, mon_w.addr, mon_w.data, mon_w.strb);
        end
      end
    end
    if (axi_bvalid && axi_bready) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL unexpected_b got bid=%h bresp=%0d, required no response", axi_bid,
                 axi_bresp);
      end else begin
        mon_b = exp_b.pop_front();
        if ({axi_bid, axi_bresp} !== mon_b) begin
          errors++;
          $display("FAIL b_resp got bid=%h bresp=%0d, required bid=%h bresp=%0d", axi_bid,
                   axi_bresp, mon_b.id, mon_b.resp);
        end
      end
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] s);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.strb = s;
    exp_wr.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] id, input logic resp);
    b_t e;
    e.id   = id;
    e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    axi_awid    = id;
    axi_awaddr  = addr;
    axi_awlen   = len;
    axi_awsize  = size;
    axi_awburst = burst;
    axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!axi_awready) begin
      errors++;
      $display("FAIL aw_timeout got awready=0, required 1 within 50 cycles");
    end
    @(posedge clk);
    #1 axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    int n;
    axi_wdata  = d;
    axi_wstrb  = s;
    axi_wlast  = last;
    axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!axi_wready) begin
      errors++;
      $display("FAIL w_timeout got wready=0, required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_wr.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_b.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d writes %0d responses pending, required 0", name,
               exp_wr.size(), exp_b.size());
      exp_wr.delete();
      exp_b.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid, mem_we, mem_addr, mem_wdata,
         mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got awready=%0d wready=%0d bvalid=%0d mem_we=%0d, required 0",
               axi_awready, axi_wready, axi_bvalid, mem_we);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (axi_awready !== 1'b0) begin
      errors++;
      $display("FAIL reset_awready_early got %0d, required 0", axi_awready);
    end
    @(negedge clk);
    checks++;
    if (axi_awready !== 1'b1 || axi_wready !== 1'b0) begin
      errors++;
      $display("FAIL reset_awready_rise got awready=%0d wready=%0d, required 1 0", axi_awready,
               axi_wready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_incr;
    logic [63:0] d;
    wr_cyc.delete();
    push_b(8'h11, 1'b0);
    send_aw(8'h11, 16'h0040, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      push_wr(10'(8 + i), d, 8'hFF);
      send_w(d, 8'hFF, i == 3);
    end
    drain("incr");
    checks++;
    if (wr_cyc.size() != 4 || (wr_cyc[3] - wr_cyc[0]) != 3) begin
      errors++;
      $display("FAIL incr_consecutive got %0d writes, required 4 on consecutive cycles",
               wr_cyc.size());
    end
  endtask

  task automatic test_wrap;
    logic [63:0] d;
    logic [9:0]  a [4];
    a[0] = 10'd11;
    a[1] = 10'd8;
    a[2] = 10'd9;
    a[3] = 10'd10;
    push_b(8'h22, 1'b0);
    send_aw(8'h22, 16'h0058, 8'd3, 3'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom};
      push_wr(a[i], d, 8'hFF);
      send_w(d, 8'hFF, i == 3);
    end
    drain("wrap");
  endtask

  task automatic test_fixed;
    logic [63:0] d;
    logic [7:0]  s [3];
    s[0] = 8'h0F;
    s[1] = 8'hF0;
    s[2] = 8'h01;
    push_b(8'h33, 1'b0);
    send_aw(8'h33, 16'h0010, 8'd2, 3'd3, 2'b00);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      push_wr(10'd2, d, s[i]);
      send_w(d, s[i], i == 2);
    end
    drain("fixed");
  endtask

  task automatic test_early_last;
    logic [63:0] d;
    push_b(8'h44, 1'b1);
    send_aw(8'h44, 16'h0000, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      push_wr(10'(i), d, 8'hFF);
      send_w(d, 8'hFF, i == 2);
    end
    drain("early_last");
    d = {$urandom, $urandom};
    push_b(8'h45, 1'b0);
    push_wr(10'd3, d, 8'hFF);
    send_aw(8'h45, 16'h0018, 8'd0, 3'd3, 2'b01);
    send_w(d, 8'hFF, 1'b1);
    drain("after_early_last");
  endtask

  task automatic test_bad_cmd;
    push_b(8'h50, 1'b1);
    send_aw(8'h50, 16'h0000, 8'd3, 3'd4, 2'b01);
    for (int i = 0; i < 4; i++) send_w({$urandom, $urandom}, 8'hFF, i == 3);
    drain("bad_size");
    push_b(8'h51, 1'b1);
    send_aw(8'h51, 16'h2000, 8'd0, 3'd3, 2'b01);
    send_w({$urandom, $urandom}, 8'hFF, 1'b1);
    drain("out_of_range");
    push_b(8'h52, 1'b1);
    send_aw(8'h52, 16'h0000, 8'd2, 3'd3, 2'b10);
    for (int i = 0; i < 3; i++) send_w({$urandom, $urandom}, 8'hFF, i == 2);
    drain("bad_wrap_len");
  endtask

  task automatic test_b_stall;
    logic [63:0] d0, d1;
    logic        exp_awready;
    int          n;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    axi_bready = 1'b0;
    push_b(8'h5A, 1'b0);
    push_wr(10'h20, d0, 8'hFF);
    send_aw(8'h5A, 16'h0100, 8'd0, 3'd3, 2'b01);
    send_w(d0, 8'hFF, 1'b1);
    n = 0;
    @(negedge clk);
    while (!axi_bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!axi_bvalid) begin
      errors++;
      $display("FAIL stall_bvalid got 0, required 1");
    end
    @(posedge clk);
    #1;
    axi_awid    = 8'h66;
    axi_awaddr  = 16'h0108;
    axi_awlen   = 8'd0;
    axi_awsize  = 3'd3;
    axi_awburst = 2'b01;
    axi_awvalid = 1'b1;
    push_b(8'h66, 1'b0);
    push_wr(10'h21, d1, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
`ifdef AXI_WR_SLAVE_AW_PREFETCH_EN
      exp_awready = (i == 0);
`else
      exp_awready = 1'b0;
`endif
      checks++;
      if (axi_bvalid !== 1'b1 || axi_bid !== 8'h5A || axi_wready !== 1'b0 ||
          axi_awready !== exp_awready) begin
        errors++;
        $display("FAIL stall_hold got bvalid=%0d bid=%h wready=%0d awready=%0d, required 1 5a 0 %0d",
                 axi_bvalid, axi_bid, axi_wready, axi_awready, exp_awready);
      end
`ifdef AXI_WR_SLAVE_AW_PREFETCH_EN
      if (i == 0) begin
        @(posedge clk);
        #1 axi_awvalid = 1'b0;
      end
`endif
    end
    @(posedge clk);
    #1 axi_bready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    axi_wdata  = d1;
    axi_wstrb  = 8'hFF;
    axi_wlast  = 1'b1;
    axi_wvalid = 1'b1;
    @(negedge clk);
`ifdef AXI_WR_SLAVE_AW_PREFETCH_EN
    checks++;
    if (axi_wready !== 1'b1 || axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL prefetch_resume got wready=%0d bvalid=%0d, required 1 0", axi_wready,
               axi_bvalid);
    end
    @(posedge clk);
    #1;
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
`else
    checks++;
    if (axi_awready !== 1'b1 || axi_bvalid !== 1'b0 || axi_wready !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got awready=%0d bvalid=%0d wready=%0d, required 1 0 0",
               axi_awready, axi_bvalid, axi_wready);
    end
    @(posedge clk);
    #1 axi_awvalid = 1'b0;
    send_w(d1, 8'hFF, 1'b1);
`endif
    drain("b_stall");
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    d = {$urandom, $urandom};
    push_wr(10'd16, d, 8'hFF);
    send_aw(8'h33, 16'h0080, 8'd3, 3'd3, 2'b01);
    send_w(d, 8'hFF, 1'b0);
    rst_n      = 1'b0;
    axi_wdata  = {$urandom, $urandom};
    axi_wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    axi_wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid, mem_we, mem_addr, mem_wdata,
         mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got awready=%0d wready=%0d bvalid=%0d mem_we=%0d, required 0",
               axi_awready, axi_wready, axi_bvalid, mem_we);
    end
    @(negedge clk);
    checks++;
    if (axi_awready !== 1'b1 || axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recover got awready=%0d bvalid=%0d, required 1 0", axi_awready,
               axi_bvalid);
    end
    @(posedge clk);
    #1;
    push_b(8'h77, 1'b0);
    for (int i = 0; i < 2; i++) push_wr(10'(1 + i), 64'(i) + 64'h1234, 8'hFF);
    send_aw(8'h77, 16'h0008, 8'd1, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) send_w(64'(i) + 64'h1234, 8'hFF, i == 1);
    drain("after_midreset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish, required completion within time limit");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    axi_awid    = '0;
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awsize  = '0;
    axi_awburst = '0;
    axi_awlock  = 1'b0;
    axi_awcache = '0;
    axi_awprot  = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b1;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_early_last();
    test_bad_cmd();
    test_b_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
